// File: rtl/reg_file_param_if.sv
// Register-file access bundle: two read ports, ALU and writeback write ports, load-issue pending marks.
// The decode/execute side holds the master modport; the register file holds the slave modport.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_pend1;
  logic              rd_pend2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           wb_en, wb_addr, wb_data, pend_set, pend_addr,
    input  rd_data1, rd_data2, rd_pend1, rd_pend2, pend_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           wb_en, wb_addr, wb_data, pend_set, pend_addr,
    output rd_data1, rd_data2, rd_pend1, rd_pend2, pend_cnt
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file with load scoreboard: 2 combinational reads, ALU + writeback writes.
// Reads are zero-latency (optional write-through bypass); writes and pending bits update on clk; no backpressure.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

  logic wr_ok, wb_ok, set_ok, inc, dec;

  assign wr_ok  = bus.wr_en    && !(ZR && bus.wr_addr   == '0);
  assign wb_ok  = bus.wb_en    && !(ZR && bus.wb_addr   == '0);
  assign set_ok = bus.pend_set && !(ZR && bus.pend_addr == '0);

  // A re-issued load to the register being written back keeps it pending.
  assign inc = set_ok && !pend_q[bus.pend_addr];
  assign dec = bus.wb_en && pend_q[bus.wb_addr]
               && !(set_ok && bus.pend_addr == bus.wb_addr);

  always_comb begin
    pend_d = pend_q;
    if (bus.wb_en) pend_d[bus.wb_addr] = 1'b0;
    if (set_ok)    pend_d[bus.pend_addr] = 1'b1;
  end

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (inc && !dec)      pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(1);
    else if (dec && !inc) pend_cnt_d = pend_cnt_q - (ADDR_W+1)'(1);
  end

  // On a port collision the ALU write is issued last so it is the one stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (wb_ok) mem_q[bus.wb_addr] <= bus.wb_data;
      if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  logic [ADDR_W-1:0] ra    [2];
  logic [DATA_W-1:0] rdat  [2];
  logic              rpend [2];

  assign ra[0] = bus.rd_addr1;
  assign ra[1] = bus.rd_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p]  = mem_q[ra[p]];
      rpend[p] = pend_q[ra[p]];
      if (BP) begin
        if (bus.wb_en && bus.wb_addr == ra[p]) begin
          rdat[p] = bus.wb_data;
          if (!(bus.pend_set && bus.pend_addr == ra[p])) rpend[p] = 1'b0;
        end
        if (bus.wr_en && bus.wr_addr == ra[p]) rdat[p] = bus.wr_data;
      end
      if (!rst_n || (ZR && ra[p] == '0)) begin
        rdat[p]  = '0;
        rpend[p] = 1'b0;
      end
    end
  end

  assign bus.rd_data1 = rdat[0];
  assign bus.rd_data2 = rdat[1];
  assign bus.rd_pend1 = rpend[0];
  assign bus.rd_pend2 = rpend[1];
  assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: bypass and non-bypass instances share stimulus, plus a narrow 16x8 instance.
module tb_reg_file_param;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  assign ifb.rd_addr1  = ifa.rd_addr1;
  assign ifb.rd_addr2  = ifa.rd_addr2;
  assign ifb.wr_en     = ifa.wr_en;
  assign ifb.wr_addr   = ifa.wr_addr;
  assign ifb.wr_data   = ifa.wr_data;
  assign ifb.wb_en     = ifa.wb_en;
  assign ifb.wb_addr   = ifa.wb_addr;
  assign ifb.wb_data   = ifa.wb_data;
  assign ifb.pend_set  = ifa.pend_set;
  assign ifb.pend_addr = ifa.pend_addr;

  localparam int A_D1 = 0, A_D2 = 1, A_P1 = 2, A_P2 = 3, A_CNT = 4;
  localparam int B_D1 = 5, B_P1 = 6, B_CNT = 7;
  localparam int C_D1 = 8, C_P1 = 9, C_CNT = 10;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      A_D1:    return ifa.rd_data1;
      A_D2:    return ifa.rd_data2;
      A_P1:    return 32'(ifa.rd_pend1);
      A_P2:    return 32'(ifa.rd_pend2);
      A_CNT:   return 32'(ifa.pend_cnt);
      B_D1:    return ifb.rd_data1;
      B_P1:    return 32'(ifb.rd_pend1);
      B_CNT:   return 32'(ifb.pend_cnt);
      C_D1:    return 32'(ifc.rd_data1);
      C_P1:    return 32'(ifc.rd_pend1);
      C_CNT:   return 32'(ifc.pend_cnt);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.wr_en = 1'b0; ifa.wb_en = 1'b0; ifa.pend_set = 1'b0;
  endtask

  task automatic idle_c();
    ifc.wr_en = 1'b0; ifc.wb_en = 1'b0; ifc.pend_set = 1'b0;
  endtask

  initial begin
    ifa.rd_addr1 = '0; ifa.rd_addr2 = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.wb_addr = '0; ifa.wb_data = '0; ifa.pend_addr = '0;
    ifc.rd_addr1 = '0; ifc.rd_addr2 = '0; ifc.wr_addr = '0; ifc.wr_data = '0;
    ifc.wb_addr = '0; ifc.wb_data = '0; ifc.pend_addr = '0;
    idle_a();
    idle_c();
    #1 rst_n = 1'b0;

    // Held in reset: a live bypass write must not show through.
    #1;
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'h0000_00A5; ifa.rd_addr1 = 5'd5;
    #1;
    sb_push("rst_bypass_a", A_D1, 32'h0);
    sb_push("rst_bypass_b", B_D1, 32'h0);
    sb_drain();
    idle_a();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      ifa.rd_addr1 = 5'(i);
      ifa.rd_addr2 = 5'(31 - i);
      #1;
      sb_push($sformatf("rst_d1_r%0d", i), A_D1, 32'h0);
      sb_push($sformatf("rst_d2_r%0d", 31 - i), A_D2, 32'h0);
      sb_push($sformatf("rst_p1_r%0d", i), A_P1, 32'h0);
      sb_drain();
    end
    sb_push("rst_cnt_a", A_CNT, 32'h0);
    sb_push("rst_cnt_b", B_CNT, 32'h0);
    sb_drain();

    // Write r5, visible same cycle only with bypass.
    cyc();
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'h0000_00A5; ifa.rd_addr1 = 5'd5;
    #2;
    sb_push("wr5_same_a", A_D1, 32'h0000_00A5);
    sb_push("wr5_same_b", B_D1, 32'h0);
    sb_drain();
    cyc();
    idle_a();
    #1;
    sb_push("wr5_next_a", A_D1, 32'h0000_00A5);
    sb_push("wr5_next_b", B_D1, 32'h0000_00A5);
    sb_drain();

    // Register 0 ignores writes and pending marks.
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 32'hFFFF_FFFF;
    ifa.pend_set = 1'b1; ifa.pend_addr = 5'd0; ifa.rd_addr1 = 5'd0;
    #2;
    sb_push("r0_same_d", A_D1, 32'h0);
    sb_push("r0_same_p", A_P1, 32'h0);
    sb_drain();
    cyc();
    idle_a();
    #1;
    sb_push("r0_next_d", A_D1, 32'h0);
    sb_push("r0_next_p", A_P1, 32'h0);
    sb_push("r0_cnt", A_CNT, 32'h0);
    sb_push("r0_next_b", B_D1, 32'h0);
    sb_drain();

    // Port collision on r7 while r7 is pending.
    ifa.pend_set = 1'b1; ifa.pend_addr = 5'd7;
    cyc();
    idle_a();
    ifa.rd_addr1 = 5'd7;
    #1;
    sb_push("r7_pend_a", A_P1, 32'h1);
    sb_push("r7_pend_b", B_P1, 32'h1);
    sb_push("r7_cnt", A_CNT, 32'h1);
    sb_drain();
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd7; ifa.wr_data = 32'h0000_1111;
    ifa.wb_en = 1'b1; ifa.wb_addr = 5'd7; ifa.wb_data = 32'h0000_2222;
    #1;
    sb_push("coll_same_d", A_D1, 32'h0000_1111);
    sb_push("coll_same_p", A_P1, 32'h0);
    sb_push("coll_same_pb", B_P1, 32'h1);
    sb_push("coll_same_db", B_D1, 32'h0);
    sb_drain();
    cyc();
    idle_a();
    #1;
    sb_push("coll_d_a", A_D1, 32'h0000_1111);
    sb_push("coll_d_b", B_D1, 32'h0000_1111);
    sb_push("coll_p", A_P1, 32'h0);
    sb_push("coll_cnt_a", A_CNT, 32'h0);
    sb_push("coll_cnt_b", B_CNT, 32'h0);
    sb_drain();

    // Scoreboard: three loads in flight.
    ifa.pend_set = 1'b1;
    ifa.pend_addr = 5'd3; cyc();
    ifa.pend_addr = 5'd4; cyc();
    ifa.pend_addr = 5'd9; cyc();
    idle_a();
    sb_push("sb_cnt3_a", A_CNT, 32'd3);
    sb_push("sb_cnt3_b", B_CNT, 32'd3);
    sb_drain();

    // Re-issue on r3 together with its writeback: stays pending.
    ifa.pend_set = 1'b1; ifa.pend_addr = 5'd3;
    ifa.wb_en = 1'b1; ifa.wb_addr = 5'd3; ifa.wb_data = 32'h0000_3333; ifa.rd_addr1 = 5'd3;
    #2;
    sb_push("reiss_same_p", A_P1, 32'h1);
    sb_push("reiss_same_d", A_D1, 32'h0000_3333);
    sb_push("reiss_same_pb", B_P1, 32'h1);
    sb_drain();
    cyc();
    idle_a();
    #1;
    sb_push("reiss_p", A_P1, 32'h1);
    sb_push("reiss_d", A_D1, 32'h0000_3333);
    sb_push("reiss_cnt", A_CNT, 32'd3);
    sb_drain();

    // Writeback to r4 clears its pending bit.
    ifa.wb_en = 1'b1; ifa.wb_addr = 5'd4; ifa.wb_data = 32'h0000_BEEF;
    ifa.rd_addr1 = 5'd4; ifa.rd_addr2 = 5'd4;
    #2;
    sb_push("wb4_same_p", A_P1, 32'h0);
    sb_push("wb4_same_d", A_D2, 32'h0000_BEEF);
    sb_push("wb4_same_pb", B_P1, 32'h1);
    sb_push("wb4_same_db", B_D1, 32'h0);
    sb_drain();
    cyc();
    idle_a();
    #1;
    sb_push("wb4_d_a", A_D1, 32'h0000_BEEF);
    sb_push("wb4_p_a", A_P1, 32'h0);
    sb_push("wb4_cnt_a", A_CNT, 32'd2);
    sb_push("wb4_p_b", B_P1, 32'h0);
    sb_push("wb4_d_b", B_D1, 32'h0000_BEEF);
    sb_push("wb4_cnt_b", B_CNT, 32'd2);
    sb_drain();

    // Set r10 and clear r9 on the same edge.
    ifa.pend_set = 1'b1; ifa.pend_addr = 5'd10;
    ifa.wb_en = 1'b1; ifa.wb_addr = 5'd9; ifa.wb_data = 32'h0000_0099;
    cyc();
    idle_a();
    ifa.rd_addr1 = 5'd10; ifa.rd_addr2 = 5'd9;
    #1;
    sb_push("swap_cnt", A_CNT, 32'd2);
    sb_push("swap_p10", A_P1, 32'h1);
    sb_push("swap_p9", A_P2, 32'h0);
    sb_drain();

    // Writeback to a register that is not pending.
    ifa.wb_en = 1'b1; ifa.wb_addr = 5'd12; ifa.wb_data = 32'h0000_000C;
    cyc();
    idle_a();
    ifa.rd_addr1 = 5'd12;
    #1;
    sb_push("wb12_cnt", A_CNT, 32'd2);
    sb_push("wb12_d", A_D1, 32'h0000_000C);
    sb_drain();

    // Asynchronous reset mid-stream with enables active.
    cyc();
    ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'h0000_DEAD;
    ifa.pend_set = 1'b1; ifa.pend_addr = 5'd11;
    ifa.rd_addr1 = 5'd3; ifa.rd_addr2 = 5'd5;
    #2 rst_n = 1'b0;
    #1;
    sb_push("arst_cnt_a", A_CNT, 32'h0);
    sb_push("arst_cnt_b", B_CNT, 32'h0);
    sb_push("arst_d1", A_D1, 32'h0);
    sb_push("arst_d2", A_D2, 32'h0);
    sb_push("arst_db", B_D1, 32'h0);
    sb_drain();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    idle_a();
    #1;
    sb_push("post_rst_d_a", A_D1, 32'h0000_DEAD);
    sb_push("post_rst_d_b", B_D1, 32'h0000_DEAD);
    sb_push("post_rst_r5", A_D2, 32'h0);
    sb_push("post_rst_cnt_a", A_CNT, 32'd1);
    sb_push("post_rst_cnt_b", B_CNT, 32'd1);
    sb_drain();

    // Narrow instance: pending count saturates at depth-1.
    cyc();
    for (int i = 0; i < 8; i++) begin
      ifc.pend_set = 1'b1;
      ifc.pend_addr = 3'(i);
      cyc();
    end
    idle_c();
    sb_push("c_cnt_full", C_CNT, 32'd7);
    sb_drain();
    ifc.pend_set = 1'b1; ifc.pend_addr = 3'd5;
    cyc();
    idle_c();
    ifc.rd_addr1 = 3'd0;
    #1;
    sb_push("c_cnt_resat", C_CNT, 32'd7);
    sb_push("c_p0", C_P1, 32'h0);
    sb_drain();
    ifc.rd_addr1 = 3'd7;
    #1;
    sb_push("c_p7", C_P1, 32'h1);
    sb_drain();
    ifc.wr_en = 1'b1; ifc.wr_addr = 3'd6; ifc.wr_data = 16'hABCD;
    cyc();
    ifc.wr_addr = 3'd0; ifc.wr_data = 16'hFFFF;
    cyc();
    idle_c();
    ifc.rd_addr1 = 3'd6;
    #1;
    sb_push("c_d6", C_D1, 32'h0000_ABCD);
    sb_drain();
    ifc.rd_addr1 = 3'd0;
    #1;
    sb_push("c_d0", C_D1, 32'h0);
    sb_drain();
    ifc.wb_en = 1'b1; ifc.wb_addr = 3'd2; ifc.wb_data = 16'h2222;
    cyc();
    idle_c();
    ifc.rd_addr1 = 3'd2;
    #1;
    sb_push("c_wb2_cnt", C_CNT, 32'd6);
    sb_push("c_wb2_d", C_D1, 32'h0000_2222);
    sb_push("c_wb2_p", C_P1, 32'h0);
    sb_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the processor's 32x32 register file.
- Features: configurable width/depth, two combinational read ports, two synchronous write ports (ALU write port and load-writeback port), optional hardwired-zero register 0, and optional same-cycle write-to-read bypass.
- Adds a per-register pending (scoreboard) bit set at load issue and cleared at writeback, plus a pending-count output; decode uses these for stall decisions.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads 0, writes/pending-sets to it ignored
BYPASS, 1, 1: reads return data being written this cycle (write-through)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_data2  out  DATA_W  read port 2 data (combinational)
rd_pend1  out  1  pending bit of rd_addr1 (combinational)
rd_pend2  out  1  pending bit of rd_addr2 (combinational)
wr_en  in  1  ALU write enable
wr_addr  in  ADDR_W  ALU write address
wr_data  in  DATA_W  ALU write data
wb_en  in  1  load-writeback write enable; also clears pending
wb_addr  in  ADDR_W  writeback address
wb_data  in  DATA_W  writeback data
pend_set  in  1  mark pend_addr pending (load issued)
pend_addr  in  ADDR_W  register to mark pending
pend_cnt  out  ADDR_W+1  number of registers currently pending (registered)

Behaviour:
- Reset (rst_n=0, async): all registers to 0, all pending bits to 0, pend_cnt=0. rd_data*=0 and rd_pend*=0 while held in reset. There are no initial-block preloads; software/testbench writes initial values.
- Writes occur on the rising clk edge only; there are no level-sensitive writes.
- Write-port collision (wr_en & wb_en, wr_addr==wb_addr): wr_data is stored; the wb write is dropped, but its pending-clear still takes effect.
- Pending update per register r, same edge:
  - set if pend_set & pend_addr==r;
  - else cleared if wb_en & wb_addr==r;
  - set wins over clear on the same register (re-issued load).
- wr_en does not affect pending bits.
- ZERO_REG=1: register 0 never written and never pending; rd_data=0 and rd_pend=0 for address 0; pend_set to 0 ignored (pend_cnt unchanged).
- Reads, BYPASS=1, per port, priority order:
  - address 0 with ZERO_REG → 0;
  - wr_en & wr_addr match → wr_data;
  - wb_en & wb_addr match → wb_data;
  - else stored value.
- rd_pend with BYPASS=1: 0 if wb_en & wb_addr matches and no pend_set to the same address this cycle; else stored bit.
- BYPASS=0: reads return stored value/bit only; a write becomes visible the cycle after the edge.
- pend_cnt: registered popcount of pending bits after each edge. Update per edge = +1 if a set lands on a non-pending register, −1 if a clear lands on a pending register (different registers), net 0 otherwise. It never exceeds 2**ADDR_W (or 2**ADDR_W−1 with ZERO_REG) and never underflows; a wb to a non-pending register leaves it unchanged.
- Reset asserted mid-operation clears everything immediately regardless of enables. The first edge after rst_n deassertion behaves normally.
- Out-of-range addresses are impossible by construction (depth = 2**ADDR_W).

Test Plan:
1. Reset then read all addresses → rd_data1/2=0, rd_pend=0, pend_cnt=0. Write r5=0x0000_00A5 (wr_en) → same-cycle rd_addr1=5 gives 0xA5 (BYPASS=1); next cycle stored 0xA5.
2. ZERO_REG: wr_en, wr_addr=0, wr_data=0xFFFF_FFFF; pend_set addr 0 → rd_data1@0 stays 0, rd_pend1=0, pend_cnt=0.
3. Collision: wr_en r7=0x1111, wb_en r7=0x2222 same edge, r7 pending beforehand → r7=0x1111, r7 pending cleared, pend_cnt decremented 1→0.
4. Scoreboard: pend_set r3, r4, r9 over 3 cycles → pend_cnt=3. Same edge pend_set r3 & wb r3 → r3 stays pending, count 3. wb r4=0xBEEF → rd_pend for r4 =0 same cycle, r4=0xBEEF, count 2.
5. Simultaneous set r10 and clear r9 → count unchanged (2); wb to non-pending r12 → count unchanged.
6. Assert rst_n low mid-stream with wr_en=1, pend_set=1 → all regs 0, pend_cnt=0 immediately without a clk edge. Repeat tests 1 and 4 with BYPASS=0 → writes visible only after the edge. Repeat with DATA_W=16, ADDR_W=3 → pend_cnt saturates at 7 with all regs 1..7 pending.
